mul_unit: RTL and testbench

Sequential radix-2 shift-add multiplier for the RV32M execute stage. It covers MUL, MULH, MULHSU and MULHU and uses the same START/READY/stall handshake as the divider. The execute-stage M-unit mux can therefore drive both blocks with one control pattern. It returns the full 2×INPUT_WIDTH product; the execute stage selects the low or high word.

---
 rtl/m_standard_pkg.sv | 21 ++
 rtl/mul_unit_if.sv | 33 +++
 rtl/mul_abs.sv | 16 +
 rtl/mul_unit.sv | 117 +++++++++++
 tb/tb_mul_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/m_standard_pkg.sv
`default_nettype none
// =============================================================================
//  Module      : m_standard_pkg
//  Description : Constants and types shared by the RV32M execute-stage M-unit
//                (multiplier and divider).
//  Revision    : 1.0  initial release
// =============================================================================
package m_standard_pkg;

    localparam int MUL_W = 32;
    localparam int DIV_W = 32;
    localparam int CNT_W = $clog2(MUL_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_unit_if.sv
`default_nettype none
// =============================================================================
//  Module      : mul_unit_if
//  Description : START/READY/stall handshake and operand/product bus of the
//                sequential multiplier.
//  Revision    : 1.0  initial release
// =============================================================================
interface mul_unit_if
    import m_standard_pkg::*;
#(
    parameter int INPUT_WIDTH = MUL_W
);
    logic                   STALL_MUL;
    logic                   START;
    logic                   SIGN_A;
    logic                   SIGN_B;
    logic [INPUT_WIDTH-1:0] MULTIPLICAND;
    logic [INPUT_WIDTH-1:0] MULTIPLIER;
    logic [INPUT_WIDTH-1:0] PRODUCT_LO;
    logic [INPUT_WIDTH-1:0] PRODUCT_HI;
    logic                   READY;

    modport master (
        output STALL_MUL, START, SIGN_A, SIGN_B, MULTIPLICAND, MULTIPLIER,
        input  PRODUCT_LO, PRODUCT_HI, READY
    );

    modport slave (
        input  STALL_MUL, START, SIGN_A, SIGN_B, MULTIPLICAND, MULTIPLIER,
        output PRODUCT_LO, PRODUCT_HI, READY
    );
endinterface
`default_nettype wire

// File: rtl/mul_abs.sv
`default_nettype none
// =============================================================================
//  Module      : mul_abs
//  Description : W-bit conditional two's-complement negate (out = en ? -in : in).
//  Revision    : 1.0  initial release
// =============================================================================
module mul_abs #(
    parameter int W = 32
) (
    input  wire logic [W-1:0] in,
    input  wire logic         en,
    output logic      [W-1:0] out
);
    assign out = en ? (~in + W'(1)) : in;
endmodule
`default_nettype wire

// File: rtl/mul_unit.sv
`default_nettype none
// =============================================================================
//  Module      : mul_unit
//  Description : Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU,
//                returning the full 2*INPUT_WIDTH product after W+1 cycles.
//  Revision    : 1.0  initial release
// =============================================================================
module mul_unit
    import m_standard_pkg::*;
#(
    parameter int INPUT_WIDTH = MUL_W
) (
    input  wire logic  CLK,
    input  wire logic  RSTN,
    mul_unit_if.slave  bus
);
    localparam int               c_W     = INPUT_WIDTH;
    localparam int               c_CNT_W = $clog2(INPUT_WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(INPUT_WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    mul_state_t           r_state;
    mul_state_t           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*c_W-1:0]     r_mcand;
    logic [c_W-1:0]       r_mplier;
    logic [2*c_W-1:0]     r_acc;
    logic                 r_neg;
    logic [2*c_W-1:0]     r_prod;

    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [c_W-1:0]       w_mag_a;
    logic [c_W-1:0]       w_mag_b;
    logic [2*c_W-1:0]     w_fix;

    assign w_neg_a = bus.SIGN_A & bus.MULTIPLICAND[c_W-1];
    assign w_neg_b = bus.SIGN_B & bus.MULTIPLIER[c_W-1];

    // -2^(W-1) maps to 2^(W-1), which still fits as a W-bit unsigned magnitude
    mul_abs #(.W(c_W)) u_abs_a (
        .in  (bus.MULTIPLICAND),
        .en  (w_neg_a),
        .out (w_mag_a)
    );

    mul_abs #(.W(c_W)) u_abs_b (
        .in  (bus.MULTIPLIER),
        .en  (w_neg_b),
        .out (w_mag_b)
    );

    mul_abs #(.W(2*c_W)) u_fix (
        .in  (r_acc),
        .en  (r_neg),
        .out (w_fix)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (!bus.STALL_MUL) begin
            if (bus.START) begin
                w_state_nxt = RUN;
            end else begin
                case (r_state)
                    IDLE:    w_state_nxt = IDLE;
                    RUN:     w_state_nxt = (r_cnt == c_CNT_ONE) ? FIX : RUN;
                    FIX:     w_state_nxt = IDLE;
                    default: w_state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_prod   <= '0;
        end else if (!bus.STALL_MUL) begin
            if (bus.START) begin
                r_mcand  <= {{c_W{1'b0}}, w_mag_a};
                r_mplier <= w_mag_b;
                r_neg    <= w_neg_a ^ w_neg_b;
                r_acc    <= '0;
                r_cnt    <= c_CNT_LOAD;
            end else if (r_state == RUN) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - c_CNT_ONE;
            end else if (r_state == FIX) begin
                r_prod <= w_fix;
            end
        end
    end

    // Product stays at the previous result until FIX retires a new one
    assign bus.PRODUCT_LO = r_prod[c_W-1:0];
    assign bus.PRODUCT_HI = r_prod[2*c_W-1:c_W];
    assign bus.READY      = (r_state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// =============================================================================
//  Module      : tb_mul_unit
//  Description : Directed self-checking bench for mul_unit with an expected-
//                product scoreboard.
//  Revision    : 1.0  initial release
// =============================================================================
module tb_mul_unit;
    localparam int c_W = 32;

    logic CLK;
    logic RSTN;
    int   checks   = 0;
    int   failures = 0;
    logic [2*c_W-1:0] sb[$];
    logic [2*c_W-1:0] last_prod;

    mul_unit_if #(.INPUT_WIDTH(c_W)) bus ();

    mul_unit #(.INPUT_WIDTH(c_W)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [2*c_W-1:0] obs,
                         input logic [2*c_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*c_W-1:0] product();
        return {bus.PRODUCT_HI, bus.PRODUCT_LO};
    endfunction

    // Drives START for exactly one sampled edge and records the expected result.
    task automatic do_start(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                            input logic sa, input logic sb_sign,
                            input logic [2*c_W-1:0] exp);
        bus.START        = 1'b1;
        bus.MULTIPLICAND = a;
        bus.MULTIPLIER   = b;
        bus.SIGN_A       = sa;
        bus.SIGN_B       = sb_sign;
        sb.push_back(exp);
        tick();
        bus.START = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.READY && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic retire(input string tag);
        logic [2*c_W-1:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        check(tag, product(), exp);
        last_prod = exp;
    endtask

    task automatic full_op(input string tag, input logic [c_W-1:0] a,
                           input logic [c_W-1:0] b, input logic sa,
                           input logic sb_sign, input logic [2*c_W-1:0] exp);
        int n;
        do_start(a, b, sa, sb_sign, exp);
        check({tag, "_busy"}, {63'd0, bus.READY}, 64'd0);
        check({tag, "_hold"}, product(), last_prod);
        wait_ready(n);
        check({tag, "_lat"}, 64'(n), 64'd33);
        retire(tag);
    endtask

    initial begin
        int n;
        RSTN             = 1'b0;
        bus.STALL_MUL    = 1'b0;
        bus.START        = 1'b0;
        bus.SIGN_A       = 1'b0;
        bus.SIGN_B       = 1'b0;
        bus.MULTIPLICAND = '0;
        bus.MULTIPLIER   = '0;
        last_prod        = '0;
        tick();
        tick();
        check("rst_ready", {63'd0, bus.READY}, 64'd1);
        check("rst_prod", product(), 64'd0);
        RSTN = 1'b1;
        tick();

        full_op("mulhu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
        full_op("mulh_min",  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
        full_op("mulh_m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001);
        full_op("mulhsu",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001);

        // Stall mid-RUN, with a START offered while stalled that must be ignored
        do_start(32'd7, 32'hFFFF_FFFA, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);
        for (int i = 0; i < 9; i++) tick();
        bus.STALL_MUL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.START        = (i == 2);
            bus.MULTIPLICAND = 32'd100;
            bus.MULTIPLIER   = 32'd100;
            tick();
            check("stall_ready", {63'd0, bus.READY}, 64'd0);
            check("stall_prod", product(), last_prod);
        end
        bus.START     = 1'b0;
        bus.STALL_MUL = 1'b0;
        wait_ready(n);
        check("stall_lat", 64'(9 + 5 + n), 64'd38);
        retire("stall_res");

        // Abort at cycle 10 and restart with new operands
        do_start(32'd3, 32'd5, 1'b0, 1'b0, 64'd15);
        void'(sb.pop_back());
        for (int i = 0; i < 9; i++) begin
            tick();
            check("abort_ready", {63'd0, bus.READY}, 64'd0);
        end
        do_start(32'd4, 32'd9, 1'b0, 1'b0, 64'd36);
        wait_ready(n);
        check("abort_lat", 64'(n), 64'd33);
        retire("abort_res");

        // Reset at iteration 12 of a RUN
        do_start(32'd123, 32'd456, 1'b0, 1'b0, 64'd56088);
        for (int i = 0; i < 12; i++) tick();
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        sb.delete();
        last_prod = '0;
        check("mrst_ready", {63'd0, bus.READY}, 64'd1);
        check("mrst_prod", product(), 64'd0);
        full_op("after_rst", 32'd2, 32'd3, 1'b0, 1'b0, 64'd6);

        // START coinciding with reset is dropped
        RSTN             = 1'b0;
        bus.START        = 1'b1;
        bus.MULTIPLICAND = 32'd5;
        bus.MULTIPLIER   = 32'd5;
        tick();
        RSTN      = 1'b1;
        bus.START = 1'b0;
        tick();
        check("rst_start_ready", {63'd0, bus.READY}, 64'd1);
        check("rst_start_prod", product(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
